// File: rtl/binary_to_bcd_double_dabble_pkg.sv
// Shared types and default sizing for the double-dabble binary-to-BCD converter.
package binary_to_bcd_double_dabble_pkg;

   localparam int unsigned DefaultW      = 8;
   localparam int unsigned DefaultDigits = 3;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } bcd_state_e;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_digit (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/binary_to_bcd_double_dabble.sv
// Sequential shift-and-add-3 converter from unsigned binary to packed BCD.
// Takes one valid/ready handshake in and one out, with W shift cycles in between.
module binary_to_bcd_double_dabble
   import binary_to_bcd_double_dabble_pkg::*;
#(
   parameter int unsigned W      = DefaultW,
   parameter int unsigned DIGITS = DefaultDigits
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int unsigned CntW = $clog2(W + 1);
   localparam int unsigned BcdW = 4 * DIGITS;

   bcd_state_e          state_q, state_d;
   logic [W-1:0]        bin_q, bin_d;
   logic [BcdW-1:0]     bcd_q, bcd_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [BcdW-1:0]     bcd_corr;
   logic [BcdW+W-1:0]   shifted;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3_digit u_add3 (
         .din  (bcd_q[4*g +: 4]),
         .dout (bcd_corr[4*g +: 4])
      );
   end

   // Corrected digits and the remaining binary bits move left together.
   assign shifted = {bcd_corr, bin_q} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               bin_d   = bin;
               bcd_d   = '0;
               cnt_d   = CntW'(W);
               state_d = StShift;
            end
         end
         StShift: begin
            bcd_d = shifted[BcdW+W-1:W];
            bin_d = shifted[W-1:0];
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         StIdle:  in_ready  = 1'b1;
         StDone:  out_valid = 1'b1;
         default: ;
      endcase
   end

   assign bcd = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_double_dabble.sv
// Directed and sweep checks for the double-dabble converter at default sizing.
module tb_binary_to_bcd_double_dabble;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  bin;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] bcd;

   int checks = 0;
   int errors = 0;

   binary_to_bcd_double_dabble #(
      .W      (8),
      .DIGITS (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd       (bcd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] ref_bcd(input int v);
      ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Called at the negedge just after the accepting edge; counts edges to out_valid.
   task automatic wait_result(input string tag, input logic [11:0] exp);
      int lat;
      logic digits_ok;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd8);
      check({tag, "_bcd"}, 32'(bcd), 32'(exp));
      digits_ok = (bcd[3:0] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[11:8] <= 4'd9);
      check({tag, "_digits"}, 32'(digits_ok), 32'd1);
   endtask

   // Called at a negedge in DONE; holds out_ready low for stall cycles, then releases.
   task automatic release_result(input string tag, input logic [11:0] exp, input int stall);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, "_hold_bcd"}, 32'(bcd), 32'(exp));
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
   endtask

   task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] exp,
                          input int stall);
      @(negedge clk);
      bin      = v;
      in_valid = 1'b1;
      check({tag, "_accept_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_result(tag, exp);
      release_result(tag, exp, stall);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bin       = '0;
      #12;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_bcd", 32'(bcd), 32'h000);
      @(negedge clk);
      rst_n = 1'b1;

      convert("zero", 8'd0, 12'h000, 0);
      convert("max", 8'd255, 12'h255, 0);
      convert("n99", 8'd99, 12'h099, 0);
      convert("n100", 8'd100, 12'h100, 5);

      // 77 held on the input during the whole conversion of 200.
      @(negedge clk);
      bin      = 8'd200;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bin = 8'd77;
      wait_result("n200", 12'h200);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("n200_idle_ready", 32'(in_ready), 32'd1);
      check("n200_idle_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("n77_accepted", 32'(in_ready), 32'd0);
      wait_result("n77", 12'h077);
      release_result("n77", 12'h077, 1);

      // Abort during the fourth shift cycle.
      @(negedge clk);
      bin      = 8'd123;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_bcd", 32'(bcd), 32'h000);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         logic spurious;
         spurious = 1'b0;
         repeat (12) begin
            @(negedge clk);
            if (out_valid || !in_ready) spurious = 1'b1;
         end
         check("abort_no_result", 32'(spurious), 32'd0);
      end

      for (int v = 0; v < 256; v++) begin
         convert($sformatf("sweep%0d", v), 8'(v), ref_bcd(v), int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/binary_to_bcd_double_dabble.md
BINARY_TO_BCD_DOUBLE_DABBLE -- requirements
Module: binary_to_bcd_double_dabble

Interface
REQ-001 SHALL have parameter W, default 8: width of the unsigned binary input.
REQ-002 SHALL have parameter DIGITS, default 3: number of BCD output digits; must equal ceil(W*log10(2)).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream presents a binary value.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a value.
REQ-007 SHALL have port bin, input, W bits: unsigned binary operand.
REQ-008 SHALL have port out_valid, output, 1 bit: bcd holds a finished result.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream (the Excess-3 converter stage) consumes the result.
REQ-010 SHALL have port bcd, output, 4*DIGITS bits: packed BCD result, digit 0 (units) in bits [3:0].

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE: in_ready=1, out_valid=0; on in_valid=1, capture bin into the binary shift register, clear the BCD register, load the bit counter with W, and go to SHIFT.
REQ-013 SHIFT: in_ready=0, out_valid=0; each cycle, add 3 to every BCD digit >=5, then shift the {BCD, binary} register left by one, and decrement the counter.
REQ-014 SHALL leave SHIFT for DONE on the cycle the counter reaches 0, after exactly W shift cycles.
REQ-015 Latency: out_valid SHALL rise exactly W clock edges after the accepting edge (8 for the default).
REQ-016 DONE: out_valid=1, in_ready=0; bcd SHALL hold stable until out_ready=1.
REQ-017 On out_valid=1 and out_ready=1, SHALL return to IDLE on the next edge; no new input is accepted in that same cycle.
REQ-018 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT disturb the conversion in progress.
REQ-019 Every output digit SHALL be in the range 0..9; the maximum input 2^W-1 SHALL convert exactly (255 -> 0x255).
REQ-020 bcd SHALL drive the BCD register continuously; its contents are meaningful only while out_valid=1.
REQ-021 The add-3 correction SHALL operate per 4-bit digit, on all digits in parallel; carries SHALL NOT propagate between digits.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, bcd=0, out_valid=0, in_ready=1, counter=0, and shift register=0, regardless of clk.
REQ-023 Reset asserted during SHIFT or DONE SHALL abort the conversion with no result delivered.
REQ-024 The first accept after rst_n deasserts SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-025 A shared package SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the defaults W=8 and DIGITS=3.
REQ-026 The per-digit correction SHALL be a combinational sub-module bcd_add3_digit: 4-bit in, 4-bit out, out = in+3 if in>=5, else in.
REQ-027 The block SHALL instantiate DIGITS copies of bcd_add3_digit; all sequential logic SHALL reside in the top module.

Verification
REQ-028 Reset then bin=0, in_valid pulse -> out_valid after 8 edges, bcd=0x000.
REQ-029 bin=255 -> bcd=0x255; bin=99 -> 0x099; bin=100 -> 0x100; each with latency exactly 8.
REQ-030 Hold out_ready=0 for 5 cycles in DONE -> bcd and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-031 in_valid=1 with bin=77 throughout a conversion of bin=200 -> result 0x200; 77 is accepted only after returning to IDLE.
REQ-032 rst_n pulsed low at the 4th SHIFT cycle -> out_valid=0 and in_ready=1 at once, with no spurious result after release.
REQ-033 Exhaustive sweep of bin 0..255 with random out_ready stalls -> every bcd matches the reference decimal and every digit is <=9.
